// File: rtl/comparator_1bit.sv
// rtl/comparator_1bit.sv - Parameterised magnitude comparator with one-hot GT/EQ/LT flags.
// Signed or unsigned compare, with an optional single output register stage.
module comparator_1bit #(
    parameter int WIDTH   = 1,
    parameter bit SIGNED  = 1'b0,
    parameter bit REG_OUT = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             A_greater_B,
    output logic             A_equal_B,
    output logic             A_less_B
);

    logic w_gt;
    logic w_eq;
    logic w_lt;

    generate
        if (SIGNED) begin : g_signed
            assign w_gt = $signed(A) > $signed(B);
        end else begin : g_unsigned
            assign w_gt = A > B;
        end
    endgenerate

    assign w_eq = (A == B);
    // LT is derived rather than compared so the three flags stay one-hot by construction.
    assign w_lt = ~w_gt & ~w_eq;

    generate
        if (REG_OUT) begin : g_reg
            logic [2:0] r_flags;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_flags <= 3'b000;
                end else begin
                    r_flags <= {w_gt, w_eq, w_lt};
                end
            end

            assign A_greater_B = r_flags[2];
            assign A_equal_B   = r_flags[1];
            assign A_less_B    = r_flags[0];
        end else begin : g_comb
            // Clock and reset have no function here; fold them into a sink net.
            logic w_unused;
            assign w_unused    = &{1'b0, clk, rst_n};
            assign A_greater_B = w_gt;
            assign A_equal_B   = w_eq;
            assign A_less_B    = w_lt;
        end
    endgenerate

endmodule

// File: tb/tb_comparator_1bit.sv
// tb/tb_comparator_1bit.sv - Self-checking bench for comparator_1bit across four configurations.
module tb_comparator_1bit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       a1, b1;
    logic [3:0] a4, b4;

    logic d0_gt, d0_eq, d0_lt;
    logic s1_gt, s1_eq, s1_lt;
    logic u4_gt, u4_eq, u4_lt;
    logic r4_gt, r4_eq, r4_lt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    comparator_1bit u_d0 (
        .clk(clk), .rst_n(rst_n), .A(a1), .B(b1),
        .A_greater_B(d0_gt), .A_equal_B(d0_eq), .A_less_B(d0_lt)
    );

    comparator_1bit #(.WIDTH(1), .SIGNED(1'b1), .REG_OUT(1'b0)) u_s1 (
        .clk(clk), .rst_n(rst_n), .A(a1), .B(b1),
        .A_greater_B(s1_gt), .A_equal_B(s1_eq), .A_less_B(s1_lt)
    );

    comparator_1bit #(.WIDTH(4), .SIGNED(1'b0), .REG_OUT(1'b0)) u_u4 (
        .clk(clk), .rst_n(rst_n), .A(a4), .B(b4),
        .A_greater_B(u4_gt), .A_equal_B(u4_eq), .A_less_B(u4_lt)
    );

    comparator_1bit #(.WIDTH(4), .SIGNED(1'b1), .REG_OUT(1'b1)) u_r4 (
        .clk(clk), .rst_n(rst_n), .A(a4), .B(b4),
        .A_greater_B(r4_gt), .A_equal_B(r4_eq), .A_less_B(r4_lt)
    );

    // Reference: map each operand to its numeric value, then compare integers.
    function automatic logic [2:0] model(int w, bit sgn, int a, int b);
        int va;
        int vb;
        va = a;
        vb = b;
        if (sgn && a >= (1 << (w - 1))) va = a - (1 << w);
        if (sgn && b >= (1 << (w - 1))) vb = b - (1 << w);
        if (va > vb) return 3'b100;
        if (va == vb) return 3'b010;
        return 3'b001;
    endfunction

    task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed gt/eq/lt=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic reg_step(input logic rn, input logic [3:0] a, input logic [3:0] b,
                            input string tag);
        logic [2:0] exp;
        @(negedge clk);
        rst_n = rn;
        a4    = a;
        b4    = b;
        exp   = rn ? model(4, 1'b1, int'(a), int'(b)) : 3'b000;
        @(posedge clk);
        #1;
        chk(tag, {r4_gt, r4_eq, r4_lt}, exp);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] ra, rb;
        logic       rr;

        rst_n = 1'b0;
        a1 = 1'b0; b1 = 1'b0;
        a4 = 4'h0; b4 = 4'h0;

        // Directed 1-bit vectors, 10 ns each, default and signed 1-bit instances.
        for (int i = 0; i < 4; i++) begin
            a1 = i[1];
            b1 = i[0];
            #10;
            chk("d0_vec", {d0_gt, d0_eq, d0_lt}, model(1, 1'b0, int'(a1), int'(b1)));
            chk("s1_vec", {s1_gt, s1_eq, s1_lt}, model(1, 1'b1, int'(a1), int'(b1)));
        end

        // Unsigned 4-bit combinational, exhaustive plus boundaries.
        for (int i = 0; i < 256; i++) begin
            a4 = i[7:4];
            b4 = i[3:0];
            #2;
            chk("u4_exh", {u4_gt, u4_eq, u4_lt}, model(4, 1'b0, int'(a4), int'(b4)));
        end
        a4 = 4'hF; b4 = 4'h0; #2;
        chk("u4_max_zero", {u4_gt, u4_eq, u4_lt}, 3'b100);
        a4 = 4'hF; b4 = 4'hF; #2;
        chk("u4_ones", {u4_gt, u4_eq, u4_lt}, 3'b010);

        // Registered signed 4-bit: reset, directed, exhaustive, hold, randomized.
        reg_step(1'b0, 4'h3, 4'h3, "r4_rst0");
        reg_step(1'b0, 4'h3, 4'h3, "r4_rst1");
        reg_step(1'b1, 4'hF, 4'h1, "r4_neg1_lt_1");
        chk("r4_dir_lt", {r4_gt, r4_eq, r4_lt}, 3'b001);
        reg_step(1'b1, 4'h7, 4'h8, "r4_7_gt_neg8");
        chk("r4_dir_gt", {r4_gt, r4_eq, r4_lt}, 3'b100);

        for (int i = 0; i < 256; i++) begin
            reg_step(1'b1, i[7:4], i[3:0], "r4_exh");
        end

        for (int i = 0; i < 3; i++) begin
            reg_step(1'b1, 4'h9, 4'h2, "r4_hold");
        end

        for (int i = 0; i < 300; i++) begin
            ra = 4'($urandom);
            rb = 4'($urandom);
            rr = ($urandom_range(0, 7) != 0);
            reg_step(rr, ra, rb, "r4_rand");
        end

        // Reset mid-stream discards the in-flight compare.
        reg_step(1'b1, 4'h5, 4'h5, "r4_pre_rst");
        reg_step(1'b0, 4'h1, 4'h2, "r4_mid_rst");
        reg_step(1'b1, 4'h2, 4'h1, "r4_post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
